// File: rtl/javk_biu.sv
// javk_biu: bus interface unit for the JAVK CPU.
// Accepts multi-byte read/write requests from the core over a valid/ready
// handshake and sequences them as single-byte cycles on the shared external
// bus (little-endian, fixed wait states, external ready extension).
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request (high in IDLE)
//   req_we     1 = write, 0 = read
//   req_len    byte count of request (1..MAX_BYTES valid)
//   req_addr   address of byte 0
//   req_wdata  write data, byte i at [i*DATA_W +: DATA_W]
//   rsp_valid  one-cycle completion pulse
//   rsp_err    request rejected (qualifies rsp_valid)
//   rsp_rdata  read data, little-endian, bytes >= len read as 0
//   bus_rdy    external device ready; low stretches the current byte
//   databus    shared data bus, driven only while rw = 1
//   addrbus    external address, registered
//   rw         1 = write cycle, 0 = read/idle
module javk_biu #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 16,
   parameter int MAX_BYTES = 2,
   parameter int WAIT      = 0,
   localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [LEN_W-1:0]              req_len,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [DATA_W*MAX_BYTES-1:0]   req_wdata,
   output logic                          rsp_valid,
   output logic                          rsp_err,
   output logic [DATA_W*MAX_BYTES-1:0]   rsp_rdata,
   input  logic                          bus_rdy,
   inout  wire  [DATA_W-1:0]             databus,
   output logic [ADDR_W-1:0]             addrbus,
   output logic                          rw
);

   localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_BYTES);
   localparam logic [3:0]       WAIT_C = 4'(WAIT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                        state, state_d;
   logic [LEN_W-1:0]              len_q;
   logic [LEN_W-1:0]              idx;
   logic                          we_q;
   logic [DATA_W*MAX_BYTES-1:0]   wdata_q;
   logic [3:0]                    cnt;
   logic                          err_q;
   logic [DATA_W-1:0]             dout;

   logic accept;
   logic reject;
   logic byte_done;
   logic last_byte;

   always_comb begin
      accept    = req_valid && (state == IDLE);
      reject    = (req_len == '0) || (req_len > MAX_L);
      byte_done = (state == ACCESS) && (cnt == '0) && bus_rdy;
      last_byte = (idx == len_q - LEN_W'(1));
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = reject ? DONE : ACCESS;
         ACCESS:  if (byte_done && last_byte) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Combinational outputs
   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == DONE);
      rsp_err   = err_q;
      dout      = '0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         if (idx == LEN_W'(i)) dout = wdata_q[i*DATA_W +: DATA_W];
      end
   end

   // rw is registered, so the data bus turns around exactly with it.
   assign databus = rw ? dout : 'z;

   // State register and datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         addrbus   <= '0;
         rw        <= 1'b0;
         rsp_rdata <= '0;
         err_q     <= 1'b0;
         len_q     <= '0;
         idx       <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         cnt       <= '0;
      end else begin
         state <= state_d;
         case (state)
            IDLE: begin
               if (accept) begin
                  err_q <= reject;
                  // Rejected requests leave the bus and read data untouched.
                  if (!reject) begin
                     addrbus <= req_addr;
                     rw      <= req_we;
                     we_q    <= req_we;
                     len_q   <= req_len;
                     wdata_q <= req_wdata;
                     idx     <= '0;
                     cnt     <= WAIT_C;
                     if (!req_we) rsp_rdata <= '0;
                  end
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
               end else if (bus_rdy) begin
                  if (!we_q) begin
                     for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                        if (idx == LEN_W'(i)) rsp_rdata[i*DATA_W +: DATA_W] <= databus;
                     end
                  end
                  if (last_byte) begin
                     rw <= 1'b0;
                  end else begin
                     idx     <= idx + LEN_W'(1);
                     addrbus <= addrbus + ADDR_W'(1);
                     cnt     <= WAIT_C;
                  end
               end
            end
            DONE:    rw <= 1'b0;
            default: rw <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/javk_biu.md
Name: javk_biu

Overview:
Parametrised bus interface unit for the JAVK CPU. It accepts multi-byte read and write requests from the core over a valid/ready handshake. It then sequences them as single-byte cycles on the shared external databus/addrbus/rw bus: little-endian byte order, programmable wait states and external ready extension. Fetch, operand, PC and stack transfers wider than the bus go through this block.

Parameters:
DATA_W, 8, external data bus width in bits (one "byte" = DATA_W bits)
ADDR_W, 16, address bus width
MAX_BYTES, 2, maximum bytes per request (>=1)
WAIT, 0, fixed wait cycles added to every byte cycle (0..15)
(localparam LEN_W = $clog2(MAX_BYTES+1))

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = write, 0 = read
req_len  input  LEN_W  byte count of request
req_addr  input  ADDR_W  address of byte 0
req_wdata  input  DATA_W*MAX_BYTES  write data, byte i at [i*DATA_W +: DATA_W]
rsp_valid  output  1  one-cycle completion pulse
rsp_err  output  1  request rejected (qualifies rsp_valid)
rsp_rdata  output  DATA_W*MAX_BYTES  read data, little-endian
bus_rdy  input  1  external device ready; low stretches current byte
databus  inout  DATA_W  shared data bus, driven only while rw=1
addrbus  output  ADDR_W  external address, registered
rw  output  1  1 = write cycle (block drives databus), 0 = read/idle

Behaviour:
- Reset (rst low, async):
  - state IDLE
  - addrbus=0, rw=0, rsp_valid=0, rsp_err=0, rsp_rdata=0
  - databus released (Z)
  - req_ready=1 once rst is deasserted.
- Reset mid-transfer aborts immediately: bus released, no rsp_valid is produced, the latched request is discarded.
- req_ready = (state==IDLE). Accept occurs on a rising edge with req_valid && req_ready. At accept, the block latches addr, len, we and wdata; later changes on req_* are ignored.
- States: IDLE, ACCESS, DONE.
- IDLE -> DONE with err:
  - condition: req_len==0 or req_len>MAX_BYTES
  - no bus activity; rw stays 0, addrbus unchanged
  - rsp_rdata unchanged
- IDLE -> ACCESS on valid accept:
  - addrbus<=req_addr, rw<=req_we
  - byte index idx<=0, wait counter<=WAIT
  - rsp_rdata cleared to 0 on read accepts.
- ACCESS:
  - Outputs: addrbus = base+idx (mod 2^ADDR_W, wraps FFFF->0000); rw = we for the whole transfer, with no idle gap between bytes.
  - Write data: dataout = wdata byte idx.
  - Wait counter: decrements each cycle while >0.
  - Byte completion: when counter==0 and bus_rdy==1.
    - Reads capture databus into rsp_rdata byte idx.
    - If idx==len-1: ->DONE, rw<=0.
    - Else: idx++, addrbus++, counter<=WAIT.
  - While counter==0 and bus_rdy==0: hold all outputs (unbounded stall).
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_err=1 only for rejected requests.
  - rw=0.
  - Next cycle -> IDLE.
- Latency, with bus_rdy held 1 and accept in cycle 0:
  - ACCESS occupies cycles 1..n*(WAIT+1).
  - rsp_valid is high in cycle n*(WAIT+1)+1.
  - Rejected request: rsp_valid high in cycle 1.
- rsp_rdata:
  - Bytes >= len read as 0.
  - Holds its value until the next accepted read; writes leave it unchanged.
- rsp_err: cleared on the next accept.
- A request presented during DONE is not accepted; it is taken in the following IDLE cycle, giving one IDLE cycle between transfers.
- databus: driven only while rw=1; Z otherwise, including during reset.
- Widths: addr increment truncates to ADDR_W; idx sized LEN_W.

Test Plan:
- Reset then 2-byte read at 0x1234, WAIT=0, device returns 0xAB then 0xCD -> addrbus 0x1234,0x1235 in cycles 1,2; rw=0; rsp_valid cycle 3, rsp_rdata=0xCDAB, rsp_err=0.
- 2-byte write 0xBEEF to 0x8000, WAIT=2 -> rw=1 cycles 1..6; databus 0xEF at 0x8000 (cycles 1-3), 0xBE at 0x8001 (4-6); rsp_valid cycle 7, then rw=0, databus Z.
- 2-byte read at 0xFFFF -> second byte addressed at 0x0000 (wrap); rsp_rdata assembled little-endian.
- bus_rdy held low 5 cycles on byte 0 of 1-byte write, WAIT=0 -> addrbus/rw/databus stable throughout; rsp_valid 1 cycle after bus_rdy rises.
- req_len=0 and req_len=3 (MAX_BYTES=2) -> rsp_valid+rsp_err in cycle 1; rw never 1; rsp_rdata unchanged.
- rst pulled low in middle of a 2-byte write (idx=1) -> rw=0, addrbus=0, databus Z immediately; no rsp_valid; req_ready=1 after release; next request completes normally.
